// File: rtl/lists_cmd_issuer.sv
// lists_cmd_issuer: credit-tracked, collision-free, gap-spaced issuer of lists_manager command pulses.
// Defining LISTS_CMD_STATS_EN adds stat_issued_out/stat_stall_out counters.
module lists_cmd_issuer #(
  parameter int CMD_DEPTH = 15,
  parameter int MIN_GAP = 2
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic [2:0]  req_op_in,
  input  logic [31:0] req_addrtcb_in,
  input  logic [5:0]  req_priority_in,
  input  logic [7:0]  req_idtask_in,
  input  logic [31:0] req_valdelay_in,
  output logic        insnew_rdylist_out,
  output logic        ins_rdylist_out,
  output logic        susp_rdylist_out,
  output logic        del_rdylist_out,
  output logic        ins_dlylist_out,
  output logic [31:0] addrtcb_out,
  output logic [5:0]  priority_out,
  output logic [7:0]  idtask_out,
  output logic [31:0] valdelay_out,
  input  logic        set_rdytask_in,
  input  logic        done_rdylist_in,
  output logic [4:0]  credits_out,
  output logic        err_illegal_out,
  output logic        err_credit_out
`ifdef LISTS_CMD_STATS_EN
  ,
  output logic [31:0] stat_issued_out,
  output logic [31:0] stat_stall_out
`endif
);
  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
  localparam logic [7:0] GAP_LAST = 8'(MIN_GAP - 1);
  state_t      state_q;
  logic [2:0]  op_q;
  logic [31:0] addr_q, dly_q;
  logic [5:0]  prio_q;
  logic [7:0]  id_q, gap_q;
  logic [4:0]  credits_q, credits_d;
  logic        err_illegal_q, err_credit_q, cred_err, hs, issue;
  logic [6:0]  sum;
  assign req_ready_out = (state_q == IDLE) && !areset;
  assign hs = req_valid_in && req_ready_out;
  // A wake-up in the same cycle always wins over a command pulse
  assign issue = (state_q == ISSUE) && (credits_q != 5'd0) && !set_rdytask_in && !areset;
  assign insnew_rdylist_out = issue && (op_q == 3'd0);
  assign ins_rdylist_out    = issue && (op_q == 3'd1);
  assign susp_rdylist_out   = issue && (op_q == 3'd2);
  assign del_rdylist_out    = issue && (op_q == 3'd3);
  assign ins_dlylist_out    = issue && (op_q == 3'd4);
  assign addrtcb_out  = issue ? addr_q : '0;
  assign priority_out = issue ? prio_q : '0;
  assign idtask_out   = issue ? id_q : '0;
  assign valdelay_out = issue ? dly_q : '0;
  assign credits_out  = credits_q;
  assign err_illegal_out = err_illegal_q;
  assign err_credit_out  = err_credit_q;
  always_comb begin
    sum = {2'b00, credits_q} - 7'(issue) - 7'(set_rdytask_in) + 7'(done_rdylist_in);
    cred_err = sum[6] || (sum > 7'(CMD_DEPTH));
    credits_d = sum[6] ? 5'd0 : (sum > 7'(CMD_DEPTH)) ? 5'(CMD_DEPTH) : sum[4:0];
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      gap_q <= '0;
      credits_q <= 5'(CMD_DEPTH);
      err_illegal_q <= 1'b0;
      err_credit_q <= 1'b0;
      op_q <= '0;
      addr_q <= '0;
      prio_q <= '0;
      id_q <= '0;
      dly_q <= '0;
    end else begin
      credits_q <= credits_d;
      err_credit_q <= cred_err;
      err_illegal_q <= hs && (req_op_in > 3'd4);
      case (state_q)
        IDLE: if (hs && (req_op_in <= 3'd4)) begin
          op_q <= req_op_in;
          addr_q <= req_addrtcb_in;
          prio_q <= req_priority_in;
          id_q <= req_idtask_in;
          dly_q <= req_valdelay_in;
          state_q <= ISSUE;
        end
        ISSUE: if (issue) begin
          gap_q <= '0;
          state_q <= (MIN_GAP == 0) ? IDLE : GAP;
        end
        GAP: if (gap_q == GAP_LAST) state_q <= IDLE;
             else gap_q <= gap_q + 8'd1;
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef LISTS_CMD_STATS_EN
  logic [31:0] stat_issued_q, stat_stall_q;
  always_ff @(posedge aclk) begin
    if (areset) begin
      stat_issued_q <= '0;
      stat_stall_q <= '0;
    end else begin
      if (issue) stat_issued_q <= stat_issued_q + 32'd1;
      if ((state_q == ISSUE) && !issue) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end
  assign stat_issued_out = stat_issued_q;
  assign stat_stall_out = stat_stall_q;
`endif
endmodule

// File: tb/tb_lists_cmd_issuer.sv
// tb_lists_cmd_issuer: vector table, hand-written corner sequences and a randomized run against a cycle model.
module tb_lists_cmd_issuer;
  localparam int DEPTH = 15;
  localparam int MIN_GAP = 2;
  localparam logic [31:0] A0 = 32'h1000_0040;
  localparam logic [5:0]  P0 = 6'd5;
  localparam logic [7:0]  I0 = 8'd3;
  localparam logic [31:0] D0 = 32'h55;
  logic aclk = 1'b0;
  logic areset, valid, ready, set, done;
  logic [2:0] op;
  logic [31:0] addr, dly, addr_o, dly_o;
  logic [5:0] prio, prio_o;
  logic [7:0] id, id_o;
  logic p_new, p_ins, p_susp, p_del, p_dly, e_ill, e_cred;
  logic [4:0] credits;
  int n_cmp = 0, n_bad = 0;
  typedef logic [90:0] snap_t;
  always #5 aclk = ~aclk;
  lists_cmd_issuer #(.CMD_DEPTH(DEPTH), .MIN_GAP(MIN_GAP)) dut (
    .aclk(aclk), .areset(areset), .req_valid_in(valid), .req_ready_out(ready),
    .req_op_in(op), .req_addrtcb_in(addr), .req_priority_in(prio), .req_idtask_in(id),
    .req_valdelay_in(dly), .insnew_rdylist_out(p_new), .ins_rdylist_out(p_ins),
    .susp_rdylist_out(p_susp), .del_rdylist_out(p_del), .ins_dlylist_out(p_dly),
    .addrtcb_out(addr_o), .priority_out(prio_o), .idtask_out(id_o), .valdelay_out(dly_o),
    .set_rdytask_in(set), .done_rdylist_in(done), .credits_out(credits),
    .err_illegal_out(e_ill), .err_credit_out(e_cred)
  );
  function automatic snap_t snap();
    return {ready, p_new, p_ins, p_susp, p_del, p_dly, credits, e_ill, e_cred, addr_o, prio_o, id_o, dly_o};
  endfunction
  function automatic snap_t mk(input logic r, input logic [4:0] p, input logic [4:0] c, input logic ei,
                               input logic ec, input logic [31:0] a, input logic [5:0] pr,
                               input logic [7:0] i, input logic [31:0] d);
    return {r, p, c, ei, ec, a, pr, i, d};
  endfunction
  task automatic chk(input string nm, input snap_t exp);
    n_cmp++;
    if (snap() !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (ready,pulses,credits,errs,addr,prio,id,delay)", nm, snap(), exp);
    end
  endtask
  task automatic chk_int(input string nm, input int got, input int lo, input int hi);
    n_cmp++;
    if (got < lo || got > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, got, lo, hi);
    end
  endtask
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask
  task automatic idle_in();
    valid = 0; op = 0; addr = 0; prio = 0; id = 0; dly = 0; set = 0; done = 0;
  endtask
  task automatic do_reset();
    areset = 1;
    idle_in();
    tick();
    @(negedge aclk);
    chk("reset", mk(1'b0, 5'd0, 5'(DEPTH), 1'b0, 1'b0, '0, '0, '0, '0));
    tick();
    areset = 0;
  endtask
  task automatic send(input logic [2:0] o, input logic [7:0] i, input logic [31:0] a, input logic [5:0] p);
    bit got = 0;
    valid = 1; op = o; id = i; addr = a; prio = p;
    for (int k = 0; k < 50; k++) begin
      @(negedge aclk);
      if (ready) begin got = 1; break; end
      tick();
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: ready stayed %b, required 1", ready);
    end
    tick();
    valid = 0;
  endtask
  typedef struct {
    logic v; logic [2:0] op; logic set; logic done;
    logic rdy; logic [4:0] pul; logic [4:0] cred;
  } vec_t;
  vec_t tv[9];
  int last_p, pulses;
  int m_cred, m_gap;
  bit m_busy, m_eill, m_ecred, iss, rdy;
  logic [2:0] m_op;
  logic [31:0] m_a, m_d;
  logic [5:0] m_p;
  logic [7:0] m_i;
  int nx, pct_done;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tv[0] = '{1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 5'b00000, 5'd15};
    tv[1] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 5'b10000, 5'd15};
    tv[2] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'd14};
    tv[3] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'd14};
    tv[4] = '{1'b1, 3'd2, 1'b1, 1'b0, 1'b1, 5'b00000, 5'd14};
    tv[5] = '{1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 5'b00000, 5'd13};
    tv[6] = '{1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 5'b00000, 5'd12};
    tv[7] = '{1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 5'b00100, 5'd11};
    tv[8] = '{1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 5'b00000, 5'd10};
    do_reset();
    addr = A0; prio = P0; id = I0; dly = D0;
    for (int i = 0; i < 9; i++) begin
      valid = tv[i].v; op = tv[i].op; set = tv[i].set; done = tv[i].done;
      @(negedge aclk);
      chk($sformatf("vec%0d", i), mk(tv[i].rdy, tv[i].pul, tv[i].cred, 1'b0, 1'b0,
          (tv[i].pul != 0) ? A0 : '0, (tv[i].pul != 0) ? P0 : '0,
          (tv[i].pul != 0) ? I0 : '0, (tv[i].pul != 0) ? D0 : '0));
      tick();
    end
    // credit exhaustion: 15 issue, the 16th waits for a done
    do_reset();
    for (int i = 0; i < 15; i++) begin
      send(3'd1, 8'(i), '0, '0);
      @(negedge aclk);
      chk($sformatf("exhaust%0d", i), mk(1'b0, 5'b01000, 5'(DEPTH - i), 1'b0, 1'b0, '0, '0, 8'(i), '0));
      tick();
    end
    send(3'd1, 8'd15, '0, '0);
    repeat (3) tick();
    @(negedge aclk);
    chk("starved", mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, '0, '0, '0, '0));
    tick();
    done = 1;
    tick();
    done = 0;
    @(negedge aclk);
    chk("refill_issue", mk(1'b0, 5'b01000, 5'd1, 1'b0, 1'b0, '0, '0, 8'd15, '0));
    tick();
    @(negedge aclk);
    chk("refill_after", mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, '0, '0, '0, '0));
    // done netted against issue at credits 7
    do_reset();
    for (int i = 0; i < 8; i++) send(3'd1, 8'(i), '0, '0);
    send(3'd1, 8'd8, '0, '0);
    done = 1;
    @(negedge aclk);
    chk("net_issue", mk(1'b0, 5'b01000, 5'd7, 1'b0, 1'b0, '0, '0, 8'd8, '0));
    tick();
    done = 0;
    @(negedge aclk);
    chk("net_after", mk(1'b0, 5'd0, 5'd7, 1'b0, 1'b0, '0, '0, '0, '0));
    // spurious done at full credit
    do_reset();
    done = 1;
    tick();
    done = 0;
    @(negedge aclk);
    chk("overflow_err", mk(1'b1, 5'd0, 5'd15, 1'b0, 1'b1, '0, '0, '0, '0));
    tick();
    @(negedge aclk);
    chk("overflow_clear", mk(1'b1, 5'd0, 5'd15, 1'b0, 1'b0, '0, '0, '0, '0));
    // illegal opcode
    do_reset();
    send(3'd6, 8'd9, A0, P0);
    @(negedge aclk);
    chk("illegal_err", mk(1'b1, 5'd0, 5'd15, 1'b1, 1'b0, '0, '0, '0, '0));
    tick();
    @(negedge aclk);
    chk("illegal_nopulse", mk(1'b1, 5'd0, 5'd15, 1'b0, 1'b0, '0, '0, '0, '0));
    // reset while a request is held
    do_reset();
    send(3'd0, I0, A0, P0);
    areset = 1;
    @(negedge aclk);
    chk("rst_in_issue", mk(1'b0, 5'd0, 5'd15, 1'b0, 1'b0, '0, '0, '0, '0));
    tick();
    areset = 0;
    @(negedge aclk);
    chk("rst_after", mk(1'b1, 5'd0, 5'd15, 1'b0, 1'b0, '0, '0, '0, '0));
    tick();
    @(negedge aclk);
    chk("rst_discard", mk(1'b1, 5'd0, 5'd15, 1'b0, 1'b0, '0, '0, '0, '0));
    // back-to-back valid requests
    do_reset();
    valid = 1; op = 3'd3;
    last_p = -100; pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge aclk);
      if (p_del) begin
        if (pulses > 0) chk_int("b2b_spacing", c - last_p, MIN_GAP + 2, MIN_GAP + 2);
        last_p = c;
        pulses++;
      end
      tick();
    end
    valid = 0;
    chk_int("b2b_count", pulses, 9, 10);
    // randomized run against the cycle model
    do_reset();
    m_cred = DEPTH; m_gap = 0; m_busy = 0; m_eill = 0; m_ecred = 0;
    m_op = 0; m_a = 0; m_d = 0; m_p = 0; m_i = 0;
    for (int c = 0; c < 3000; c++) begin
      pct_done = (c < 1500) ? 12 : 40;
      valid = ($urandom_range(99, 0) < 55);
      op = ($urandom_range(9, 0) == 0) ? 3'($urandom_range(7, 5)) : 3'($urandom_range(4, 0));
      addr = $urandom; prio = 6'($urandom); id = 8'($urandom); dly = $urandom;
      set = ($urandom_range(99, 0) < 15);
      done = ($urandom_range(99, 0) < pct_done);
      rdy = !m_busy && m_gap == 0;
      iss = m_busy && m_cred >= 1 && !set;
      @(negedge aclk);
      chk($sformatf("rand%0d", c), mk(rdy, iss ? (5'b10000 >> m_op) : 5'd0, 5'(m_cred), m_eill, m_ecred,
          iss ? m_a : '0, iss ? m_p : '0, iss ? m_i : '0, iss ? m_d : '0));
      nx = m_cred - int'(iss) - int'(set) + int'(done);
      m_ecred = nx < 0 || nx > DEPTH;
      m_cred = nx < 0 ? 0 : nx > DEPTH ? DEPTH : nx;
      m_eill = rdy && valid && op > 4;
      if (iss) begin
        m_busy = 0;
        m_gap = MIN_GAP;
      end else if (m_gap > 0) m_gap--;
      if (rdy && valid && op <= 4) begin
        m_busy = 1; m_op = op; m_a = addr; m_p = prio; m_i = id; m_d = dly;
      end
      tick();
    end
    idle_in();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
